seq_game_ctrl: RTL

Parametrised sequence-memory game controller: grows a random colour sequence one entry per round, plays it back through a shared display timer, checks player input entry by entry, and tracks score and high score. Sits between the input encoder/debouncer, the LFSR (`RAND`), the display/tone driver (`OUT`/`OUT_ENA`) and the one-shot timer (`TIMER_GO`/`TIMER_PULSE`). Generalises the fixed 4-colour/32-deep controller to any colour width and depth, adds visible score outputs, and adds an optional input timeout.

---
 rtl/seq_game_ctrl.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/seq_game_ctrl.sv
// seq_game_ctrl: sequence-memory game controller.
//
// Each round adds one random colour (RAND) to the stored sequence and plays
// the whole sequence back through the shared one-shot timer. The player then
// has to repeat it entry by entry. Score and high score are tracked across games.
//
// Parameters:
//   COLOR_W        colour code width (2^COLOR_W colours)
//   DEPTH          maximum sequence length, 2..256
//   TIMEOUT_PULSES timer pulses allowed per input before a loss, 1..255
//
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   IN, IN_VALID        pressed colour. IN is meaningful while IN_VALID=1
//   RAND                random colour, sampled once per round
//   TIMER_PULSE         one-cycle expiry from the shared timer
//   START_GAME          level start request, only honoured in IDLE
//   OUT, OUT_ENA        colour shown and display/tone enable
//   TIMER_GO            one-cycle timer (re)start
//   WIN, LOSE           game result levels, cleared on the next start
//   HS                  one-cycle pulse when a new high score is recorded
//   SCORE, HIGH_SCORE   completed rounds of the current/last game, best since reset
//
// Input handshake: IN_VALID is a level that stays high while a button is held.
// A press is accepted on the first cycle IN_VALID=1 in INPUT, and only there
// is IN sampled. The next press is accepted only after IN_VALID returns to 0.
//
// Build option: define SEQ_GAME_TIMEOUT_EN to make INPUT restart the timer on
// entry and declare a loss after TIMEOUT_PULSES expiries with no press.
// Without it INPUT waits indefinitely and the pulse counter is absent.

module seq_game_ctrl #(
    parameter int COLOR_W        = 2,
    parameter int DEPTH          = 32,
    parameter int TIMEOUT_PULSES = 8,
    localparam int CNT_W         = $clog2(DEPTH + 1)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [COLOR_W-1:0] IN,
    input  logic               IN_VALID,
    input  logic [COLOR_W-1:0] RAND,
    input  logic               TIMER_PULSE,
    input  logic               START_GAME,
    output logic [COLOR_W-1:0] OUT,
    output logic               OUT_ENA,
    output logic               TIMER_GO,
    output logic               WIN,
    output logic               LOSE,
    output logic               HS,
    output logic [CNT_W-1:0]   SCORE,
    output logic [CNT_W-1:0]   HIGH_SCORE
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    // Out-of-range parameters leave this named block in the elaborated
    // hierarchy, so a bad configuration is visible when browsing the design.
    if (TIMEOUT_PULSES < 1 || TIMEOUT_PULSES > 255 || DEPTH < 2 || DEPTH > 256) begin : g_param_out_of_range
    end

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADD, S_SHOW, S_SHOW_WAIT, S_INPUT, S_HOLD, S_END
    } state_t;

    state_t state, state_d;

    logic [COLOR_W-1:0] stack [DEPTH];
    logic               wr_en;

    logic [CNT_W-1:0]   len, len_d;
    logic [CNT_W-1:0]   idx, idx_d;
    logic               good, good_d;
    logic [COLOR_W-1:0] out_q, out_d;
    logic               ena_q, ena_d;
    logic               go_q, go_d;
    logic               win_q, win_d;
    logic               lose_q, lose_d;
    logic               hs_q, hs_d;
    logic [CNT_W-1:0]   score_q, score_d;
    logic [CNT_W-1:0]   high_q, high_d;

    logic               match;
    logic               at_last;

`ifdef SEQ_GAME_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_PULSES - 1);
    logic [7:0] to_cnt, to_cnt_d;
    logic       to_expire;
    // The pulse that would bring the count to TIMEOUT_PULSES ends the game.
    assign to_expire = TIMER_PULSE && (to_cnt == TO_LAST);
`endif

    assign match   = (IN == stack[idx[ADDR_W-1:0]]);
    assign at_last = (idx == len - ONE_C);

    // State and all registered outputs/datapath.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= S_IDLE;
            len     <= '0;
            idx     <= '0;
            good    <= 1'b0;
            out_q   <= '1;
            ena_q   <= 1'b0;
            go_q    <= 1'b0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
            hs_q    <= 1'b0;
            score_q <= '0;
            high_q  <= '0;
`ifdef SEQ_GAME_TIMEOUT_EN
            to_cnt  <= '0;
`endif
        end else begin
            state   <= state_d;
            len     <= len_d;
            idx     <= idx_d;
            good    <= good_d;
            out_q   <= out_d;
            ena_q   <= ena_d;
            go_q    <= go_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
            hs_q    <= hs_d;
            score_q <= score_d;
            high_q  <= high_d;
`ifdef SEQ_GAME_TIMEOUT_EN
            to_cnt  <= to_cnt_d;
`endif
        end
    end

    // Sequence storage carries no reset: every entry is written before it is read.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            stack[len[ADDR_W-1:0]] <= RAND;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:      if (START_GAME) state_d = S_START;
            S_START:     if (!START_GAME) state_d = S_ADD;
            S_ADD:       state_d = (len == DEPTH_C) ? S_END : S_SHOW;
            S_SHOW:      state_d = S_SHOW_WAIT;
            S_SHOW_WAIT: if (TIMER_PULSE) state_d = at_last ? S_INPUT : S_SHOW;
            S_INPUT: begin
                if (IN_VALID) begin
                    state_d = S_HOLD;
`ifdef SEQ_GAME_TIMEOUT_EN
                end else if (to_expire) begin
                    state_d = S_END;
`endif
                end
            end
            S_HOLD: begin
                if (!IN_VALID) begin
                    if (!good)           state_d = S_END;
                    else if (idx == len) state_d = S_ADD;
                    else                 state_d = S_INPUT;
                end
            end
            S_END:       state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        len_d   = len;
        idx_d   = idx;
        good_d  = good;
        out_d   = out_q;
        ena_d   = ena_q;
        go_d    = 1'b0;
        win_d   = win_q;
        lose_d  = lose_q;
        hs_d    = 1'b0;
        score_d = score_q;
        high_d  = high_q;
        wr_en   = 1'b0;
`ifdef SEQ_GAME_TIMEOUT_EN
        to_cnt_d = to_cnt;
`endif
        case (state)
            S_IDLE: begin
                len_d = '0;
                idx_d = '0;
                if (START_GAME) begin
                    win_d   = 1'b0;
                    lose_d  = 1'b0;
                    score_d = '0;
                end
            end
            S_ADD: begin
                if (len == DEPTH_C) begin
                    win_d = 1'b1;
                end else begin
                    wr_en = 1'b1;
                    len_d = len + ONE_C;
                    idx_d = '0;
                end
            end
            S_SHOW: begin
                out_d = stack[idx[ADDR_W-1:0]];
                ena_d = 1'b1;
                go_d  = 1'b1;
            end
            S_SHOW_WAIT: begin
                if (TIMER_PULSE) begin
                    ena_d = 1'b0;
                    if (at_last) begin
                        idx_d = '0;
`ifdef SEQ_GAME_TIMEOUT_EN
                        go_d     = 1'b1;
                        to_cnt_d = '0;
`endif
                    end else begin
                        idx_d = idx + ONE_C;
                    end
                end
            end
            S_INPUT: begin
                // A press in the same cycle as the final pulse takes priority.
                if (IN_VALID) begin
                    good_d = match;
                    if (match) idx_d = idx + ONE_C;
`ifdef SEQ_GAME_TIMEOUT_EN
                end else if (TIMER_PULSE) begin
                    to_cnt_d = to_cnt + 8'd1;
                    if (to_expire) lose_d = 1'b1;
`endif
                end
            end
            S_HOLD: begin
                if (!IN_VALID) begin
                    if (!good) begin
                        lose_d = 1'b1;
                    end else if (idx == len) begin
                        score_d = len;
                    end else begin
`ifdef SEQ_GAME_TIMEOUT_EN
                        go_d     = 1'b1;
                        to_cnt_d = '0;
`endif
                    end
                end
            end
            S_END: begin
                if (score_q > high_q) begin
                    high_d = score_q;
                    hs_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign OUT        = out_q;
    assign OUT_ENA    = ena_q;
    assign TIMER_GO   = go_q;
    assign WIN        = win_q;
    assign LOSE       = lose_q;
    assign HS         = hs_q;
    assign SCORE      = score_q;
    assign HIGH_SCORE = high_q;

endmodule
